// File: rtl/cpu_pkg.sv
// Shared CPU constants for the operand-read / execute boundary.
// Holds the datapath, register-address and control-bundle widths, the bit
// positions inside the decoded control bundle, and a small helper used by the
// forwarding logic to decide whether a producer stage feeds a given source.
package cpu_pkg;

    localparam int DW = 32;
    localparam int AW = 6;
    localparam int CW = 8;

    // Control bundle bit positions
    localparam int CTRL_LOAD   = 0;
    localparam int CTRL_STORE  = 1;
    localparam int CTRL_BRANCH = 2;
    localparam int CTRL_JUMP   = 3;
    localparam int CTRL_ALUSRC = 4;
    localparam int CTRL_REGWR  = 5;

    // A set LD_BIT marks an instruction that reads memory into its rd
    localparam int LD_BIT = CTRL_LOAD;

    // A producer feeds a source when it writes back and targets that
    // register. r0 is deliberately not excluded: it is forwarded like any
    // other register.
    function automatic logic fwd_hit(input logic we,
                                     input logic [AW-1:0] prod_rd,
                                     input logic [AW-1:0] src_rd);
        return we && (prod_rd == src_rd);
    endfunction

endpackage

// File: rtl/operand_fwd_mux.sv
// Combinational four-source operand select.
// Picks the newest value of one source register: the EX result first, then
// the MEM result, then the value being written back this cycle, and finally
// the base value (fresh register-file read or the held operand).
// Ports:
//   src_rd           source register address being resolved
//   base             operand if no producer stage matches
//   ex_we/rd/data    EX-stage result
//   mem_we/rd/data   MEM-stage result
//   wb_we/rd/data    write-back port of the register file
//   operand          resolved operand
module operand_fwd_mux
    import cpu_pkg::*;
(
    input  logic [AW-1:0] src_rd,
    input  logic [DW-1:0] base,
    input  logic          ex_we,
    input  logic [AW-1:0] ex_rd,
    input  logic [DW-1:0] ex_data,
    input  logic          mem_we,
    input  logic [AW-1:0] mem_rd,
    input  logic [DW-1:0] mem_data,
    input  logic          wb_we,
    input  logic [AW-1:0] wb_rd,
    input  logic [DW-1:0] wb_data,
    output logic [DW-1:0] operand
);

    // The youngest producer wins, so the if-chain tests it first.
    always_comb begin
        operand = base;
        if (fwd_hit(ex_we, ex_rd, src_rd)) begin
            operand = ex_data;
        end else if (fwd_hit(mem_we, mem_rd, src_rd)) begin
            operand = mem_data;
        end else if (fwd_hit(wb_we, wb_rd, src_rd)) begin
            operand = wb_data;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// Operand-read / ID->EX pipeline stage placed after the 64x32 register file.
// Stage R captures the decoded fields while the register file reads rs/rt.
// Its data arrives one edge later on rf_sout/rf_tout. Stage R then resolves
// both operands with EX/MEM/WB forwarding and stage E registers them for EX.
// Load-use hazards and downstream stalls hold R. A load-use hazard also
// inserts a bubble into E.
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   id_valid/rs/rt/rd/ctrl/imm  decoded instruction from ID
//   id_ready                    decode may advance (no hold this cycle)
//   rf_sout, rf_tout            register-file read data for the captured rs/rt
//   ex_fwd_*, mem_fwd_*         forwarding sources from EX and MEM
//   wb_we/rd/din                register-file write port (forwarded too)
//   stall, flush                downstream hold / kill both stages
//   ex_valid/a/b/rd/ctrl/imm    registered instruction for the EX stage
module id_ex_stage
    import cpu_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          id_valid,
    input  logic [AW-1:0] id_rs,
    input  logic [AW-1:0] id_rt,
    input  logic [AW-1:0] id_rd,
    input  logic [CW-1:0] id_ctrl,
    input  logic [DW-1:0] id_imm,
    output logic          id_ready,
    input  logic [DW-1:0] rf_sout,
    input  logic [DW-1:0] rf_tout,
    input  logic          ex_fwd_we,
    input  logic [AW-1:0] ex_fwd_rd,
    input  logic [DW-1:0] ex_fwd_data,
    input  logic          mem_fwd_we,
    input  logic [AW-1:0] mem_fwd_rd,
    input  logic [DW-1:0] mem_fwd_data,
    input  logic          wb_we,
    input  logic [AW-1:0] wb_rd,
    input  logic [DW-1:0] wb_din,
    input  logic          stall,
    input  logic          flush,
    output logic          ex_valid,
    output logic [DW-1:0] ex_a,
    output logic [DW-1:0] ex_b,
    output logic [AW-1:0] ex_rd,
    output logic [CW-1:0] ex_ctrl,
    output logic [DW-1:0] ex_imm
);

    logic          r_valid;
    logic [AW-1:0] r_rs;
    logic [AW-1:0] r_rt;
    logic [AW-1:0] r_rd;
    logic [CW-1:0] r_ctrl;
    logic [DW-1:0] r_imm;
    logic [DW-1:0] r_a_hold;
    logic [DW-1:0] r_b_hold;
    logic          r_fresh;

    logic          load_use;
    logic          hold;
    logic [DW-1:0] base_a;
    logic [DW-1:0] base_b;
    logic [DW-1:0] res_a;
    logic [DW-1:0] res_b;

    // A load in E cannot forward its data until MEM, so a dependent
    // instruction in R waits one cycle.
    assign load_use = r_valid && ex_valid && ex_ctrl[LD_BIT] &&
                      ((ex_rd == r_rs) || (ex_rd == r_rt));
    assign hold     = stall || load_use;
    assign id_ready = !hold;

    // The read port follows decode every edge. Once R has held for a cycle,
    // rf_sout/rf_tout belong to the next instruction, and the operands must
    // come from the hold registers instead.
    assign base_a = r_fresh ? rf_sout : r_a_hold;
    assign base_b = r_fresh ? rf_tout : r_b_hold;

    operand_fwd_mux u_fwd_a (
        .src_rd   (r_rs),
        .base     (base_a),
        .ex_we    (ex_fwd_we),
        .ex_rd    (ex_fwd_rd),
        .ex_data  (ex_fwd_data),
        .mem_we   (mem_fwd_we),
        .mem_rd   (mem_fwd_rd),
        .mem_data (mem_fwd_data),
        .wb_we    (wb_we),
        .wb_rd    (wb_rd),
        .wb_data  (wb_din),
        .operand  (res_a)
    );

    operand_fwd_mux u_fwd_b (
        .src_rd   (r_rt),
        .base     (base_b),
        .ex_we    (ex_fwd_we),
        .ex_rd    (ex_fwd_rd),
        .ex_data  (ex_fwd_data),
        .mem_we   (mem_fwd_we),
        .mem_rd   (mem_fwd_rd),
        .mem_data (mem_fwd_data),
        .wb_we    (wb_we),
        .wb_rd    (wb_rd),
        .wb_data  (wb_din),
        .operand  (res_b)
    );

    // Flush wins over every hold.
    // On any hold, the resolved operands are re-captured each cycle, so
    // writes that land during the hold are not lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid  <= 1'b0;
            r_rs     <= '0;
            r_rt     <= '0;
            r_rd     <= '0;
            r_ctrl   <= '0;
            r_imm    <= '0;
            r_a_hold <= '0;
            r_b_hold <= '0;
            r_fresh  <= 1'b0;
            ex_valid <= 1'b0;
            ex_a     <= '0;
            ex_b     <= '0;
            ex_rd    <= '0;
            ex_ctrl  <= '0;
            ex_imm   <= '0;
        end else if (flush) begin
            r_valid  <= 1'b0;
            ex_valid <= 1'b0;
            r_fresh  <= 1'b0;
        end else if (hold) begin
            r_a_hold <= res_a;
            r_b_hold <= res_b;
            r_fresh  <= 1'b0;
            if (!stall) begin
                ex_valid <= 1'b0;
            end
        end else begin
            ex_valid <= r_valid;
            ex_a     <= res_a;
            ex_b     <= res_b;
            ex_rd    <= r_rd;
            ex_ctrl  <= r_ctrl;
            ex_imm   <= r_imm;
            r_valid  <= id_valid;
            r_rs     <= id_rs;
            r_rt     <= id_rt;
            r_rd     <= id_rd;
            r_ctrl   <= id_ctrl;
            r_imm    <= id_imm;
            r_fresh  <= 1'b1;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed testbench for id_ex_stage.
// A small behavioural register file (write-first, one-edge read latency)
// feeds rf_sout/rf_tout. Vectors are driven 1 time unit after each rising
// edge, and outputs are checked at that same point.
module tb_id_ex_stage;

    logic        clk;
    logic        rst_n;
    logic        id_valid;
    logic [5:0]  id_rs;
    logic [5:0]  id_rt;
    logic [5:0]  id_rd;
    logic [7:0]  id_ctrl;
    logic [31:0] id_imm;
    logic        id_ready;
    logic [31:0] rf_sout;
    logic [31:0] rf_tout;
    logic        ex_fwd_we;
    logic [5:0]  ex_fwd_rd;
    logic [31:0] ex_fwd_data;
    logic        mem_fwd_we;
    logic [5:0]  mem_fwd_rd;
    logic [31:0] mem_fwd_data;
    logic        wb_we;
    logic [5:0]  wb_rd;
    logic [31:0] wb_din;
    logic        stall;
    logic        flush;
    logic        ex_valid;
    logic [31:0] ex_a;
    logic [31:0] ex_b;
    logic [5:0]  ex_rd;
    logic [7:0]  ex_ctrl;
    logic [31:0] ex_imm;

    logic [31:0] regs [0:63];
    int          checkCount;
    int          passCount;

    id_ex_stage dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_valid     (id_valid),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_rd        (id_rd),
        .id_ctrl      (id_ctrl),
        .id_imm       (id_imm),
        .id_ready     (id_ready),
        .rf_sout      (rf_sout),
        .rf_tout      (rf_tout),
        .ex_fwd_we    (ex_fwd_we),
        .ex_fwd_rd    (ex_fwd_rd),
        .ex_fwd_data  (ex_fwd_data),
        .mem_fwd_we   (mem_fwd_we),
        .mem_fwd_rd   (mem_fwd_rd),
        .mem_fwd_data (mem_fwd_data),
        .wb_we        (wb_we),
        .wb_rd        (wb_rd),
        .wb_din       (wb_din),
        .stall        (stall),
        .flush        (flush),
        .ex_valid     (ex_valid),
        .ex_a         (ex_a),
        .ex_b         (ex_b),
        .ex_rd        (ex_rd),
        .ex_ctrl      (ex_ctrl),
        .ex_imm       (ex_imm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file model: samples addresses every edge, write-first
    always @(posedge clk) begin
        rf_sout <= (wb_we && wb_rd == id_rs) ? wb_din : regs[id_rs];
        rf_tout <= (wb_we && wb_rd == id_rt) ? wb_din : regs[id_rt];
        if (wb_we) begin
            regs[wb_rd] <= wb_din;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [5:0] rs,
                                 input logic [5:0] rt, input logic [5:0] rd,
                                 input logic [7:0] ctrl, input logic [31:0] imm);
        id_valid = v;
        id_rs    = rs;
        id_rt    = rt;
        id_rd    = rd;
        id_ctrl  = ctrl;
        id_imm   = imm;
    endtask

    task automatic clearFwd();
        ex_fwd_we  = 1'b0;
        mem_fwd_we = 1'b0;
        wb_we      = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Preload contents: {address, value}
    logic [5:0]  preAddr [6];
    logic [31:0] preVal  [6];

    initial begin
        checkCount = 0;
        passCount  = 0;
        preAddr = '{6'd0, 6'd1, 6'd2, 6'd3, 6'd8, 6'd9};
        preVal  = '{32'h0, 32'h21, 32'h0, 32'h5, 32'h11, 32'h3};

        rst_n = 1'b0;
        stall = 1'b0;
        flush = 1'b0;
        ex_fwd_rd = '0; ex_fwd_data = '0;
        mem_fwd_rd = '0; mem_fwd_data = '0;
        wb_rd = '0; wb_din = '0;
        clearFwd();
        applyStimulus(1'b0, 6'd0, 6'd0, 6'd0, 8'h0, 32'h0);

        // Fill register-file model through its write port while in reset
        for (int i = 0; i < 6; i++) begin
            wb_we  = 1'b1;
            wb_rd  = preAddr[i];
            wb_din = preVal[i];
            tick();
        end
        wb_we = 1'b0;
        applyStimulus(1'b0, 6'd0, 6'd0, 6'd0, 8'h0, 32'h0);
        checkOutput("reset ex_valid", {31'b0, ex_valid}, 32'h0);
        checkOutput("reset ex_a", ex_a, 32'h0);
        checkOutput("reset id_ready", {31'b0, id_ready}, 32'h1);
        #3 rst_n = 1'b1;
        tick();

        // 1 Plain: rs=3 (5), rt=2 (0)
        applyStimulus(1'b1, 6'd3, 6'd2, 6'd4, 8'h0, 32'h7);
        tick();
        applyStimulus(1'b0, 6'd0, 6'd0, 6'd0, 8'h0, 32'h0);
        tick();
        checkOutput("plain ex_valid", {31'b0, ex_valid}, 32'h1);
        checkOutput("plain ex_a", ex_a, 32'h5);
        checkOutput("plain ex_b", ex_b, 32'h0);
        checkOutput("plain ex_rd", {26'b0, ex_rd}, 32'h4);
        checkOutput("plain ex_imm", ex_imm, 32'h7);

        // 2 Priority on rs=rt=6: all three -> EX, then MEM, then WB
        for (int c = 0; c < 3; c++) begin
            applyStimulus(1'b1, 6'd6, 6'd6, 6'd20, 8'h0, 32'h0);
            tick();
            applyStimulus(1'b0, 6'd0, 6'd0, 6'd0, 8'h0, 32'h0);
            ex_fwd_we  = (c == 0);  ex_fwd_rd  = 6'd6; ex_fwd_data  = 32'hA;
            mem_fwd_we = (c <= 1);  mem_fwd_rd = 6'd6; mem_fwd_data = 32'hB;
            wb_we      = 1'b1;      wb_rd      = 6'd6; wb_din       = 32'hC;
            tick();
            clearFwd();
            checkOutput($sformatf("prio%0d ex_a", c), ex_a, 32'hA + 32'(c));
            checkOutput($sformatf("prio%0d ex_b", c), ex_b, 32'hA + 32'(c));
        end
        // r0 forwarded like any register; rt=6 now holds 0xC
        applyStimulus(1'b1, 6'd0, 6'd6, 6'd21, 8'h0, 32'h0);
        tick();
        applyStimulus(1'b0, 6'd0, 6'd0, 6'd0, 8'h0, 32'h0);
        ex_fwd_we = 1'b1; ex_fwd_rd = 6'd0; ex_fwd_data = 32'h99;
        tick();
        clearFwd();
        checkOutput("r0 fwd ex_a", ex_a, 32'h99);
        checkOutput("r0 base ex_b", ex_b, 32'hC);

        // 3 Load-use: load rd=8, then consumer rs=8
        applyStimulus(1'b1, 6'd1, 6'd1, 6'd8, 8'h01, 32'h0);
        tick();
        applyStimulus(1'b1, 6'd8, 6'd1, 6'd9, 8'h0, 32'h0);
        tick();
        checkOutput("lu id_ready low", {31'b0, id_ready}, 32'h0);
        applyStimulus(1'b0, 6'd0, 6'd0, 6'd0, 8'h0, 32'h0);
        tick();
        checkOutput("lu bubble ex_valid", {31'b0, ex_valid}, 32'h0);
        checkOutput("lu id_ready high", {31'b0, id_ready}, 32'h1);
        mem_fwd_we = 1'b1; mem_fwd_rd = 6'd8; mem_fwd_data = 32'h55;
        tick();
        clearFwd();
        checkOutput("lu ex_valid", {31'b0, ex_valid}, 32'h1);
        checkOutput("lu ex_a", ex_a, 32'h55);
        checkOutput("lu ex_b", ex_b, 32'h21);
        checkOutput("lu ex_rd", {26'b0, ex_rd}, 32'h9);

        // 4 Stall 3 cycles, wb(9,0x77) mid-stall, R has rt=9
        applyStimulus(1'b1, 6'd1, 6'd1, 6'd11, 8'h0, 32'h44);
        tick();
        applyStimulus(1'b1, 6'd1, 6'd9, 6'd10, 8'h0, 32'h0);
        tick();
        applyStimulus(1'b0, 6'd0, 6'd0, 6'd0, 8'h0, 32'h0);
        stall = 1'b1;
        for (int s = 0; s < 3; s++) begin
            wb_we = (s == 1); wb_rd = 6'd9; wb_din = 32'h77;
            tick();
            wb_we = 1'b0;
            checkOutput($sformatf("stall%0d ex_rd", s), {26'b0, ex_rd}, 32'd11);
            checkOutput($sformatf("stall%0d ex_imm", s), ex_imm, 32'h44);
            checkOutput($sformatf("stall%0d id_ready", s), {31'b0, id_ready}, 32'h0);
        end
        stall = 1'b0;
        tick();
        checkOutput("stall rel ex_valid", {31'b0, ex_valid}, 32'h1);
        checkOutput("stall rel ex_a", ex_a, 32'h21);
        checkOutput("stall rel ex_b", ex_b, 32'h77);
        checkOutput("stall rel ex_rd", {26'b0, ex_rd}, 32'd10);

        // 5 Flush overrides stall with both stages valid
        applyStimulus(1'b1, 6'd1, 6'd1, 6'd12, 8'h0, 32'h0);
        tick();
        applyStimulus(1'b1, 6'd1, 6'd1, 6'd13, 8'h0, 32'h0);
        tick();
        checkOutput("pre flush ex_valid", {31'b0, ex_valid}, 32'h1);
        applyStimulus(1'b0, 6'd0, 6'd0, 6'd0, 8'h0, 32'h0);
        stall = 1'b1; flush = 1'b1;
        tick();
        stall = 1'b0; flush = 1'b0;
        checkOutput("flush ex_valid", {31'b0, ex_valid}, 32'h0);
        tick();
        checkOutput("flush r_valid drained", {31'b0, ex_valid}, 32'h0);
        applyStimulus(1'b1, 6'd1, 6'd3, 6'd14, 8'h0, 32'h5);
        tick();
        applyStimulus(1'b0, 6'd0, 6'd0, 6'd0, 8'h0, 32'h0);
        tick();
        checkOutput("post flush ex_valid", {31'b0, ex_valid}, 32'h1);
        checkOutput("post flush ex_rd", {26'b0, ex_rd}, 32'd14);
        checkOutput("post flush ex_b", ex_b, 32'h5);

        // 6 Asynchronous reset between edges
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async ex_valid", {31'b0, ex_valid}, 32'h0);
        checkOutput("async ex_a", ex_a, 32'h0);
        checkOutput("async ex_rd", {26'b0, ex_rd}, 32'h0);
        #1 rst_n = 1'b1;
        tick();
        applyStimulus(1'b1, 6'd3, 6'd1, 6'd15, 8'h0, 32'h9);
        tick();
        applyStimulus(1'b0, 6'd0, 6'd0, 6'd0, 8'h0, 32'h0);
        tick();
        checkOutput("after reset ex_valid", {31'b0, ex_valid}, 32'h1);
        checkOutput("after reset ex_a", ex_a, 32'h5);
        checkOutput("after reset ex_imm", ex_imm, 32'h9);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
